// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/div into HI/LO, plus mthi/mtlo/mfhi/mflo.
// Result is computed on the launch edge and held pending until the busy counter expires.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] RD
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_pend_hi;
  logic [31:0]   r_pend_lo;
  logic          r_pend_wr;
  logic          r_busy;
  logic [CW-1:0] r_cnt;

  // PC is carried for debug visibility only.
  logic w_pc_unused;
  assign w_pc_unused = ^PC;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_launch;
  logic        w_signed;
  logic [63:0] w_prod;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_div_zero;

  assign w_is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
  assign w_is_div = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
  assign w_launch = Start && !r_busy && (w_is_mul || w_is_div);
  assign w_signed = (MDUOp == OP_MULT) || (MDUOp == OP_DIV);

  always_comb begin
    w_prod = 64'd0;
    if (w_signed)
      w_prod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    else
      w_prod = {32'd0, A} * {32'd0, B};
  end

  // Signed divide via magnitudes: quotient truncates toward zero, remainder follows the dividend.
  assign w_a_mag    = (w_signed && A[31]) ? (~A + 32'd1) : A;
  assign w_b_mag    = (w_signed && B[31]) ? (~B + 32'd1) : B;
  assign w_div_zero = (B == 32'd0);
  assign w_b_safe   = w_div_zero ? 32'd1 : w_b_mag;
  assign w_q_mag    = w_a_mag / w_b_safe;
  assign w_r_mag    = w_a_mag % w_b_safe;
  assign w_quot     = (w_signed && (A[31] ^ B[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem      = (w_signed && A[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        if (r_pend_wr) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end
    end else if (w_launch) begin
      r_busy <= 1'b1;
      if (w_is_mul) begin
        r_cnt     <= CW'(MULT_CYCLES);
        r_pend_hi <= w_prod[63:32];
        r_pend_lo <= w_prod[31:0];
        r_pend_wr <= 1'b1;
      end else begin
        r_cnt     <= CW'(DIV_CYCLES);
        r_pend_hi <= w_rem;
        r_pend_lo <= w_quot;
        r_pend_wr <= !w_div_zero;
      end
    end else if (MDUOp == OP_MTHI) begin
      r_hi <= A;
    end else if (MDUOp == OP_MTLO) begin
      r_lo <= A;
    end
  end

  always_comb begin
    RD = 32'd0;
    if (MDUOp == OP_MFHI)
      RD = r_hi;
    else if (MDUOp == OP_MFLO)
      RD = r_lo;
  end

  assign Busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: arithmetic results, busy length, ignored starts/moves, reset abort.
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] RD;

  int checks = 0;
  int errors = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .PC    (PC),
    .A     (A),
    .B     (B),
    .MDUOp (MDUOp),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO),
    .RD    (RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch op, then count busy cycles and note whether HI/LO moved while busy.
  task automatic launch_and_wait(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int cyc, output logic stable);
    logic [31:0] hi0;
    logic [31:0] lo0;
    hi0 = HI;
    lo0 = LO;
    A = a; B = b; MDUOp = op; Start = 1'b1;
    tick();
    Start = 1'b0; MDUOp = 4'd0;
    cyc = 0;
    stable = 1'b1;
    while (Busy === 1'b1 && cyc < 40) begin
      if (HI !== hi0 || LO !== lo0) stable = 1'b0;
      cyc++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (Busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if (HI !== 32'd0)   begin errors++; $display("FAIL reset_hi: got %h want 0", HI); end
    checks++; if (LO !== 32'd0)   begin errors++; $display("FAIL reset_lo: got %h want 0", LO); end
    checks++; if (RD !== 32'd0)   begin errors++; $display("FAIL reset_rd: got %h want 0", RD); end
  endtask

  task automatic test_mult();
    int cyc;
    logic st;
    launch_and_wait(4'd1, 32'hFFFFFFFE, 32'd3, cyc, st);
    checks++; if (cyc !== 5)           begin errors++; $display("FAIL mult_busy_cycles: got %0d want 5", cyc); end
    checks++; if (st !== 1'b1)         begin errors++; $display("FAIL mult_hilo_stable: HI/LO changed while busy"); end
    checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
    checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", LO); end
  endtask

  task automatic test_multu();
    int cyc;
    logic st;
    launch_and_wait(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, st);
    checks++; if (cyc !== 5)           begin errors++; $display("FAIL multu_busy_cycles: got %0d want 5", cyc); end
    checks++; if (HI !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", HI); end
    checks++; if (LO !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", LO); end
    MDUOp = 4'd5;
    #1;
    checks++; if (RD !== 32'hFFFFFFFE) begin errors++; $display("FAIL mfhi_rd: got %h want fffffffe", RD); end
    MDUOp = 4'd6;
    #1;
    checks++; if (RD !== 32'h00000001) begin errors++; $display("FAIL mflo_rd: got %h want 00000001", RD); end
    MDUOp = 4'd0;
    #1;
    checks++; if (RD !== 32'd0)        begin errors++; $display("FAIL none_rd: got %h want 0", RD); end
  endtask

  task automatic test_div();
    int cyc;
    logic st;
    launch_and_wait(4'd3, 32'hFFFFFFF9, 32'd2, cyc, st);
    checks++; if (cyc !== 10)          begin errors++; $display("FAIL div_busy_cycles: got %0d want 10", cyc); end
    checks++; if (st !== 1'b1)         begin errors++; $display("FAIL div_hilo_stable: HI/LO changed while busy"); end
    checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", LO); end
    checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", HI); end
    launch_and_wait(4'd4, 32'hFFFFFFF9, 32'd2, cyc, st);
    checks++; if (cyc !== 10)          begin errors++; $display("FAIL divu_busy_cycles: got %0d want 10", cyc); end
    checks++; if (LO !== 32'h7FFFFFFC) begin errors++; $display("FAIL divu_lo: got %h want 7ffffffc", LO); end
    checks++; if (HI !== 32'h00000001) begin errors++; $display("FAIL divu_hi: got %h want 00000001", HI); end
  endtask

  task automatic test_move_and_div0();
    int cyc;
    logic st;
    A = 32'h12345678; MDUOp = 4'd7;
    tick();
    A = 32'h9ABCDEF0; MDUOp = 4'd8;
    tick();
    MDUOp = 4'd0;
    checks++; if (HI !== 32'h12345678) begin errors++; $display("FAIL mthi: got %h want 12345678", HI); end
    checks++; if (LO !== 32'h9ABCDEF0) begin errors++; $display("FAIL mtlo: got %h want 9abcdef0", LO); end
    launch_and_wait(4'd3, 32'd5, 32'd0, cyc, st);
    checks++; if (cyc !== 10)          begin errors++; $display("FAIL div0_busy_cycles: got %0d want 10", cyc); end
    checks++; if (HI !== 32'h12345678) begin errors++; $display("FAIL div0_hi: got %h want 12345678", HI); end
    checks++; if (LO !== 32'h9ABCDEF0) begin errors++; $display("FAIL div0_lo: got %h want 9abcdef0", LO); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    A = 32'd3; B = 32'd4; MDUOp = 4'd1; Start = 1'b1;
    tick();                                   // busy cycle 1
    Start = 1'b0; MDUOp = 4'd0;
    tick();                                   // busy cycle 2
    A = 32'hDEAD; B = 32'd1; MDUOp = 4'd3; Start = 1'b1;
    tick();                                   // busy cycle 3
    Start = 1'b0; MDUOp = 4'd7;
    tick();                                   // busy cycle 4
    MDUOp = 4'd0;
    checks++; if (HI !== 32'h12345678) begin errors++; $display("FAIL busy_mthi_ignored: got %h want 12345678", HI); end
    cyc = 3;
    while (Busy === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
    checks++; if (cyc !== 5)           begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 5", cyc); end
    checks++; if (HI !== 32'd0)        begin errors++; $display("FAIL b2b_hi: got %h want 0", HI); end
    checks++; if (LO !== 32'd12)       begin errors++; $display("FAIL b2b_lo: got %h want 0000000c", LO); end
    tick();
    tick();
    checks++; if (Busy !== 1'b0)       begin errors++; $display("FAIL b2b_div_ignored: busy got %b want 0", Busy); end
  endtask

  task automatic test_completion_edge_start();
    A = 32'd2; B = 32'd2; MDUOp = 4'd1; Start = 1'b1;
    tick();                                   // busy cycle 1
    Start = 1'b0; MDUOp = 4'd0;
    for (int i = 0; i < 4; i++) tick();       // busy cycle 5, the last one
    A = 32'd7; B = 32'd7; MDUOp = 4'd1; Start = 1'b1;
    tick();
    Start = 1'b0; MDUOp = 4'd0;
    checks++; if (Busy !== 1'b0)       begin errors++; $display("FAIL edge_start_busy: got %b want 0", Busy); end
    checks++; if (LO !== 32'd4)        begin errors++; $display("FAIL edge_start_lo: got %h want 00000004", LO); end
    tick();
    checks++; if (Busy !== 1'b0)       begin errors++; $display("FAIL edge_start_later_busy: got %b want 0", Busy); end
  endtask

  task automatic test_reset_abort();
    A = 32'd100; B = 32'd7; MDUOp = 4'd4; Start = 1'b1;
    tick();                                   // busy cycle 1
    Start = 1'b0; MDUOp = 4'd0;
    for (int i = 0; i < 3; i++) tick();       // busy cycle 4
    checks++; if (Busy !== 1'b1)       begin errors++; $display("FAIL abort_pre_busy: got %b want 1", Busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (Busy !== 1'b0)       begin errors++; $display("FAIL abort_busy: got %b want 0", Busy); end
    checks++; if (HI !== 32'd0)        begin errors++; $display("FAIL abort_hi: got %h want 0", HI); end
    checks++; if (LO !== 32'd0)        begin errors++; $display("FAIL abort_lo: got %h want 0", LO); end
    for (int i = 0; i < 12; i++) tick();
    checks++; if (HI !== 32'd0 || LO !== 32'd0)
      begin errors++; $display("FAIL abort_no_late_write: got HI=%h LO=%h want 0/0", HI, LO); end
    checks++; if (Busy !== 1'b0)       begin errors++; $display("FAIL abort_late_busy: got %b want 0", Busy); end
  endtask

  initial begin
    reset = 1'b1; PC = 32'h00400000; A = 32'd0; B = 32'd0; MDUOp = 4'd0; Start = 1'b0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_move_and_div0();
    test_back_to_back();
    test_completion_edge_start();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
